// File: rtl/vscale_hasti_arbiter_2to1_pkg.sv
// -----------------------------------------------------------------------------
// vscale_hasti_arbiter_2to1_pkg
//   Shared HASTI widths, encodings and types for the 2:1 HASTI arbiter.
//   Exports the HASTI_* widths, the transfer, burst and response encodings,
//   the pending-request record type, and the is_active() helper.
// -----------------------------------------------------------------------------
package vscale_hasti_arbiter_2to1_pkg;

    localparam int HASTI_ADDR_WIDTH  = 32;
    localparam int HASTI_BUS_WIDTH   = 32;
    localparam int HASTI_SIZE_WIDTH  = 3;
    localparam int HASTI_BURST_WIDTH = 3;
    localparam int HASTI_PROT_WIDTH  = 4;
    localparam int HASTI_TRANS_WIDTH = 2;

    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

    localparam logic [HASTI_BURST_WIDTH-1:0] HASTI_BURST_SINGLE = 3'd0;
    localparam logic                         HASTI_RESP_OKAY    = 1'b0;

    // One buffered address phase; only the fields the slave sees are kept.
    typedef struct packed {
        logic                        valid;
        logic [HASTI_ADDR_WIDTH-1:0] addr;
        logic                        write;
        logic [HASTI_SIZE_WIDTH-1:0] size;
        logic [HASTI_PROT_WIDTH-1:0] prot;
    } arb_req_t;

    // BUSY and IDLE both count as "no request".
    function automatic logic is_active(input logic [HASTI_TRANS_WIDTH-1:0] trans);
        return (trans == HASTI_TRANS_NONSEQ) || (trans == HASTI_TRANS_SEQ);
    endfunction

endpackage

// File: rtl/vscale_hasti_arb_req_buf.sv
// -----------------------------------------------------------------------------
// vscale_hasti_arb_req_buf
//   Pending address-phase register for one master of the 2:1 arbiter.
//   Holds a request that was accepted from the master but not yet granted.
// Ports
//   hclk, hresetn      clock, async active-low reset
//   capture            load in_* and set valid
//   clear              drop the entry (ignored when capture is high)
//   in_addr/write/size/prot     address phase to capture
//   pend_valid/addr/write/size/prot  stored address phase
// -----------------------------------------------------------------------------
module vscale_hasti_arb_req_buf
    import vscale_hasti_arbiter_2to1_pkg::*;
(
    input  logic                        hclk,
    input  logic                        hresetn,
    input  logic                        capture,
    input  logic                        clear,
    input  logic [HASTI_ADDR_WIDTH-1:0] in_addr,
    input  logic                        in_write,
    input  logic [HASTI_SIZE_WIDTH-1:0] in_size,
    input  logic [HASTI_PROT_WIDTH-1:0] in_prot,
    output logic                        pend_valid,
    output logic [HASTI_ADDR_WIDTH-1:0] pend_addr,
    output logic                        pend_write,
    output logic [HASTI_SIZE_WIDTH-1:0] pend_size,
    output logic [HASTI_PROT_WIDTH-1:0] pend_prot
);

    arb_req_t pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (capture) begin
            pend_d.valid = 1'b1;
            pend_d.addr  = in_addr;
            pend_d.write = in_write;
            pend_d.size  = in_size;
            pend_d.prot  = in_prot;
        end else if (clear) begin
            pend_d.valid = 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_valid = pend_q.valid;
    assign pend_addr  = pend_q.addr;
    assign pend_write = pend_q.write;
    assign pend_size  = pend_q.size;
    assign pend_prot  = pend_q.prot;

endmodule

// File: rtl/vscale_hasti_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// vscale_hasti_arbiter_2to1
//   Two-master (m0 = dmem, m1 = imem) to one-slave HASTI arbiter in front of a
//   single SRAM port. A losing master's address phase is buffered and that
//   master is stalled through its hready; the slave only ever sees
//   NONSEQ/IDLE SINGLE transfers.
// Ports
//   hclk, hresetn                          clock, async active-low reset
//   mN_haddr/hwrite/hsize/hburst/hmastlock/hprot/htrans   master N address phase
//   mN_hwdata                              master N write data
//   mN_hrdata/hready/hresp                 master N response
//   s_haddr/hwrite/hsize/hburst/hmastlock/hprot/htrans    slave address phase
//   s_hwdata                               write data of the data-phase owner
//   s_hrdata/hready/hresp                  slave response
// Configuration
//   HASTI_ARB_RR_EN  defined: round-robin on ties (master not granted last
//                    wins). Undefined: fixed priority m0 over m1.
// -----------------------------------------------------------------------------
module vscale_hasti_arbiter_2to1
    import vscale_hasti_arbiter_2to1_pkg::*;
(
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
    input  logic                         m0_hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
    input  logic [HASTI_BURST_WIDTH-1:0] m0_hburst,
    input  logic                         m0_hmastlock,
    input  logic [HASTI_PROT_WIDTH-1:0]  m0_hprot,
    input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
    output logic                         m0_hready,
    output logic                         m0_hresp,
    input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
    input  logic                         m1_hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
    input  logic [HASTI_BURST_WIDTH-1:0] m1_hburst,
    input  logic                         m1_hmastlock,
    input  logic [HASTI_PROT_WIDTH-1:0]  m1_hprot,
    input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
    output logic                         m1_hready,
    output logic                         m1_hresp,
    output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
    output logic                         s_hwrite,
    output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
    output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
    output logic                         s_hmastlock,
    output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
    output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
    output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
    input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
    input  logic                         s_hready,
    input  logic                         s_hresp
);

    logic live_0, live_1;
    logic cap_0, cap_1, clr_0, clr_1;
    logic grant_0, grant_1, grant_any;

    logic                        p0_valid, p1_valid;
    logic [HASTI_ADDR_WIDTH-1:0] p0_addr, p1_addr;
    logic                        p0_write, p1_write;
    logic [HASTI_SIZE_WIDTH-1:0] p0_size, p1_size;
    logic [HASTI_PROT_WIDTH-1:0] p0_prot, p1_prot;

    arb_req_t cand_0, cand_1;

    logic                        dp_valid_q, dp_valid_d;
    logic                        dp_owner_q, dp_owner_d;
    logic [HASTI_ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic                        hold_write_q, hold_write_d;
    logic [HASTI_SIZE_WIDTH-1:0] hold_size_q, hold_size_d;
    logic [HASTI_PROT_WIDTH-1:0] hold_prot_q, hold_prot_d;

    // Bursts are flattened and locking is not supported downstream.
    logic unused_ok;
    assign unused_ok = ^{m0_hburst, m0_hmastlock, m1_hburst, m1_hmastlock};

    // A master only presents a new address phase while its hready is high.
    assign live_0 = m0_hready & is_active(m0_htrans);
    assign live_1 = m1_hready & is_active(m1_htrans);

    vscale_hasti_arb_req_buf u_pend_0 (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .capture    (cap_0),
        .clear      (clr_0),
        .in_addr    (m0_haddr),
        .in_write   (m0_hwrite),
        .in_size    (m0_hsize),
        .in_prot    (m0_hprot),
        .pend_valid (p0_valid),
        .pend_addr  (p0_addr),
        .pend_write (p0_write),
        .pend_size  (p0_size),
        .pend_prot  (p0_prot)
    );

    vscale_hasti_arb_req_buf u_pend_1 (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .capture    (cap_1),
        .clear      (clr_1),
        .in_addr    (m1_haddr),
        .in_write   (m1_hwrite),
        .in_size    (m1_hsize),
        .in_prot    (m1_hprot),
        .pend_valid (p1_valid),
        .pend_addr  (p1_addr),
        .pend_write (p1_write),
        .pend_size  (p1_size),
        .pend_prot  (p1_prot)
    );

    // A valid pending entry holds that master's hready low, so live_N and
    // pend_N are never both set.
    always_comb begin
        if (p0_valid) begin
            cand_0 = '{valid: 1'b1, addr: p0_addr, write: p0_write, size: p0_size, prot: p0_prot};
        end else begin
            cand_0 = '{valid: live_0, addr: m0_haddr, write: m0_hwrite, size: m0_hsize, prot: m0_hprot};
        end
        if (p1_valid) begin
            cand_1 = '{valid: 1'b1, addr: p1_addr, write: p1_write, size: p1_size, prot: p1_prot};
        end else begin
            cand_1 = '{valid: live_1, addr: m1_haddr, write: m1_hwrite, size: m1_hsize, prot: m1_hprot};
        end
    end

`ifdef HASTI_ARB_RR_EN
    // last_q = 1 when m1 received the most recent grant.
    logic last_q, last_d;

    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        // hresetn gates the grant so nothing reaches the slave during reset.
        if (hresetn && s_hready) begin
            if (cand_0.valid && cand_1.valid) begin
                grant_0 = last_q;
                grant_1 = ~last_q;
            end else begin
                grant_0 = cand_0.valid;
                grant_1 = cand_1.valid;
            end
        end
        last_d = last_q;
        if (grant_1) begin
            last_d = 1'b1;
        end else if (grant_0) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        // hresetn gates the grant so nothing reaches the slave during reset.
        if (hresetn && s_hready) begin
            grant_0 = cand_0.valid;
            grant_1 = cand_1.valid & ~cand_0.valid;
        end
    end
`endif

    assign grant_any = grant_0 | grant_1;

    // Live but not granted: buffer it, since the master already saw hready=1.
    assign cap_0 = live_0 & ~grant_0;
    assign cap_1 = live_1 & ~grant_1;
    assign clr_0 = p0_valid & grant_0;
    assign clr_1 = p1_valid & grant_1;

    // The granted source passes straight through; otherwise the last
    // forwarded address phase is held on the slave bus.
    always_comb begin
        hold_addr_d  = hold_addr_q;
        hold_write_d = hold_write_q;
        hold_size_d  = hold_size_q;
        hold_prot_d  = hold_prot_q;
        if (grant_1) begin
            hold_addr_d  = cand_1.addr;
            hold_write_d = cand_1.write;
            hold_size_d  = cand_1.size;
            hold_prot_d  = cand_1.prot;
        end else if (grant_0) begin
            hold_addr_d  = cand_0.addr;
            hold_write_d = cand_0.write;
            hold_size_d  = cand_0.size;
            hold_prot_d  = cand_0.prot;
        end

        s_haddr     = hold_addr_d;
        s_hwrite    = hold_write_d;
        s_hsize     = hold_size_d;
        s_hprot     = hold_prot_d;
        s_htrans    = grant_any ? HASTI_TRANS_NONSEQ : HASTI_TRANS_IDLE;
        s_hburst    = HASTI_BURST_SINGLE;
        s_hmastlock = 1'b0;
    end

    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_owner_d = dp_owner_q;
        if (s_hready) begin
            dp_valid_d = grant_any;
            if (grant_any) begin
                dp_owner_d = grant_1;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_valid_q   <= 1'b0;
            dp_owner_q   <= 1'b0;
            hold_addr_q  <= '0;
            hold_write_q <= 1'b0;
            hold_size_q  <= '0;
            hold_prot_q  <= '0;
        end else begin
            dp_valid_q   <= dp_valid_d;
            dp_owner_q   <= dp_owner_d;
            hold_addr_q  <= hold_addr_d;
            hold_write_q <= hold_write_d;
            hold_size_q  <= hold_size_d;
            hold_prot_q  <= hold_prot_d;
        end
    end

    // Each master keeps hwdata stable until its own hready rises.
    assign s_hwdata  = dp_owner_q ? m1_hwdata : m0_hwdata;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

    always_comb begin
        m0_hready = 1'b1;
        m1_hready = 1'b1;
        m0_hresp  = HASTI_RESP_OKAY;
        m1_hresp  = HASTI_RESP_OKAY;
        if (dp_valid_q && !dp_owner_q) begin
            m0_hready = s_hready;
            m0_hresp  = s_hresp;
        end else if (p0_valid) begin
            m0_hready = 1'b0;
        end
        if (dp_valid_q && dp_owner_q) begin
            m1_hready = s_hready;
            m1_hresp  = s_hresp;
        end else if (p1_valid) begin
            m1_hready = 1'b0;
        end
    end

endmodule

// File: tb/tb_vscale_hasti_arbiter_2to1.sv
`timescale 1ns/1ps
module tb_vscale_hasti_arbiter_2to1;
    import vscale_hasti_arbiter_2to1_pkg::*;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] m0_haddr, m1_haddr;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize, m1_hsize;
    logic [2:0]  m0_hburst, m1_hburst;
    logic        m0_hmastlock, m1_hmastlock;
    logic [3:0]  m0_hprot, m1_hprot;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [31:0] m0_hwdata, m1_hwdata;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        m0_hready, m1_hready;
    logic        m0_hresp, m1_hresp;
    logic [31:0] s_haddr;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [2:0]  s_hburst;
    logic        s_hmastlock;
    logic [3:0]  s_hprot;
    logic [1:0]  s_htrans;
    logic [31:0] s_hwdata;
    logic [31:0] s_hrdata;
    logic        s_hready;
    logic        s_hresp;

    vscale_hasti_arbiter_2to1 dut (
        .hclk(hclk), .hresetn(hresetn),
        .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
        .m0_hburst(m0_hburst), .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot),
        .m0_htrans(m0_htrans), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata),
        .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
        .m1_hburst(m1_hburst), .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot),
        .m1_htrans(m1_htrans), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata),
        .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hmastlock(s_hmastlock), .s_hprot(s_hprot),
        .s_htrans(s_htrans), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
        .s_hready(s_hready), .s_hresp(s_hresp)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic [31:0] a;
        logic        w;
        logic [2:0]  sz;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wq[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Slave model: registers the accepted address phase, returns address-derived read data.
    logic        slv_dp_v, slv_dp_w;
    logic [31:0] slv_dp_a;
    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            slv_dp_v <= 1'b0;
            slv_dp_w <= 1'b0;
            slv_dp_a <= '0;
        end else if (s_hready) begin
            slv_dp_v <= (s_htrans == HASTI_TRANS_NONSEQ);
            slv_dp_w <= s_hwrite;
            slv_dp_a <= s_haddr;
        end
    end
    assign s_hrdata = rd_of(slv_dp_a);

    // Scoreboard: every accepted slave transfer and every write data beat is popped and compared.
    always @(negedge hclk) begin
        exp_t        e;
        logic [31:0] ew;
        if (hresetn) begin
            if (slv_dp_v && slv_dp_w && s_hready) begin
                ew = (wq.size() > 0) ? wq.pop_front() : 32'hx;
                check("slave_wdata", {32'd0, s_hwdata}, {32'd0, ew});
            end
            if (s_htrans == HASTI_TRANS_NONSEQ && s_hready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check("slave_addr_phase", {28'd0, s_haddr, s_hwrite, s_hsize}, {28'd0, e});
                check("slave_burst_lock", {60'd0, s_hmastlock, s_hburst}, {60'd0, 1'b0, HASTI_BURST_SINGLE});
            end
        end
    end

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic smp();
        @(negedge hclk);
    endtask

    task automatic m0_req(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] sz);
        m0_htrans = tr; m0_haddr = a; m0_hwrite = w; m0_hsize = sz;
    endtask

    task automatic m1_req(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [2:0] sz);
        m1_htrans = tr; m1_haddr = a; m1_hwrite = w; m1_hsize = sz;
    endtask

    task automatic push(input logic [31:0] a, input logic w, input logic [2:0] sz);
        exp_q.push_back({a, w, sz});
    endtask

    initial begin
        hresetn = 1'b0;
        s_hready = 1'b1; s_hresp = 1'b0;
        m0_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        m1_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        m0_hburst = HASTI_BURST_SINGLE; m1_hburst = HASTI_BURST_SINGLE;
        m0_hmastlock = 1'b0; m1_hmastlock = 1'b0;
        m0_hprot = 4'h3; m1_hprot = 4'h3;
        m0_hwdata = '0; m1_hwdata = '0;

        #2;
        check("rst_s_htrans", s_htrans, HASTI_TRANS_IDLE);
        check("rst_m0_hready", m0_hready, 1);
        check("rst_m1_hready", m1_hready, 1);
        check("rst_hresp", {m0_hresp, m1_hresp}, 0);
        cyc(); cyc();
        hresetn = 1'b1;

        // 1: lone m0 write
        cyc();
        m0_req(HASTI_TRANS_NONSEQ, 32'h100, 1'b1, 3'd2);
        push(32'h100, 1'b1, 3'd2); wq.push_back(32'hDEADBEEF);
        smp();
        check("t1_haddr", s_haddr, 32'h100);
        check("t1_htrans", s_htrans, HASTI_TRANS_NONSEQ);
        check("t1_m0_hready_a", m0_hready, 1);
        cyc();
        m0_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        m0_hwdata = 32'hDEADBEEF;
        smp();
        check("t1_hwdata", s_hwdata, 32'hDEADBEEF);
        check("t1_m0_hready_d", m0_hready, 1);

        // 2: simultaneous reads, m0 wins
        cyc();
        m0_req(HASTI_TRANS_NONSEQ, 32'h200, 1'b0, 3'd2);
        m1_req(HASTI_TRANS_NONSEQ, 32'h300, 1'b0, 3'd2);
        push(32'h200, 1'b0, 3'd2); push(32'h300, 1'b0, 3'd2);
        smp();
        check("t2_haddr_t", s_haddr, 32'h200);
        check("t2_m1_hready_t", m1_hready, 1);
        cyc();
        m0_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        m1_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        smp();
        check("t2_haddr_t1", s_haddr, 32'h300);
        check("t2_htrans_t1", s_htrans, HASTI_TRANS_NONSEQ);
        check("t2_m1_hready_t1", m1_hready, 0);
        check("t2_m0_hready_t1", m0_hready, 1);
        check("t2_m0_hrdata", m0_hrdata, rd_of(32'h200));
        cyc();
        s_hresp = 1'b1;
        smp();
        check("t2_m1_hready_t2", m1_hready, 1);
        check("t2_m1_hrdata", m1_hrdata, rd_of(32'h300));
        check("t2_m1_hresp", m1_hresp, 1);
        check("t2_m0_hresp", m0_hresp, 0);
        check("t2_htrans_t2", s_htrans, HASTI_TRANS_IDLE);

        // 3: slave stall during m0 data phase while m1 writes
        cyc();
        s_hresp = 1'b0;
        m0_req(HASTI_TRANS_NONSEQ, 32'h500, 1'b0, 3'd2);
        push(32'h500, 1'b0, 3'd2);
        smp();
        check("t3_haddr_m0", s_haddr, 32'h500);
        cyc();
        s_hready = 1'b0;
        m0_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        m1_req(HASTI_TRANS_NONSEQ, 32'h40, 1'b1, 3'd2);
        push(32'h40, 1'b1, 3'd2); wq.push_back(32'h0BADF00D);
        smp();
        check("t3_htrans_stall1", s_htrans, HASTI_TRANS_IDLE);
        check("t3_m0_hready_stall1", m0_hready, 0);
        check("t3_m1_hready_stall1", m1_hready, 1);
        cyc();
        m1_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        m1_hwdata = 32'h0BADF00D;
        smp();
        check("t3_htrans_stall2", s_htrans, HASTI_TRANS_IDLE);
        check("t3_m0_hready_stall2", m0_hready, 0);
        check("t3_m1_hready_stall2", m1_hready, 0);
        cyc();
        s_hready = 1'b1;
        smp();
        check("t3_haddr_m1", s_haddr, 32'h40);
        check("t3_htrans_m1", s_htrans, HASTI_TRANS_NONSEQ);
        check("t3_hwrite_m1", s_hwrite, 1);
        check("t3_m0_hready_done", m0_hready, 1);
        check("t3_m0_hrdata", m0_hrdata, rd_of(32'h500));
        check("t3_m1_hready_pend", m1_hready, 0);
        cyc();
        smp();
        check("t3_hwdata_m1", s_hwdata, 32'h0BADF00D);
        check("t3_m1_hready_done", m1_hready, 1);
        check("t3_htrans_after", s_htrans, HASTI_TRANS_IDLE);

        // 4: m0 streams 8 reads, m1 waits (fixed priority)
        for (int i = 0; i < 8; i++) begin
            cyc();
            m0_req(HASTI_TRANS_NONSEQ, 32'h600 + 32'(4 * i), 1'b0, 3'd2);
            push(32'h600 + 32'(4 * i), 1'b0, 3'd2);
            if (i == 0) m1_req(HASTI_TRANS_NONSEQ, 32'h700, 1'b0, 3'd2);
            else        m1_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
            smp();
            check("t4_haddr_m0", s_haddr, 32'h600 + 32'(4 * i));
            check("t4_m0_hready", m0_hready, 1);
            check("t4_m1_hready", m1_hready, (i == 0) ? 64'd1 : 64'd0);
        end
        cyc();
        m0_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        push(32'h700, 1'b0, 3'd2);
        smp();
        check("t4_haddr_m1", s_haddr, 32'h700);
        check("t4_m1_hready_wait", m1_hready, 0);
        check("t4_m0_hrdata_last", m0_hrdata, rd_of(32'h61C));
        cyc();
        smp();
        check("t4_m1_hready_done", m1_hready, 1);
        check("t4_m1_hrdata", m1_hrdata, rd_of(32'h700));

        // 5: reset while pend_1 holds an entry
        cyc();
        s_hready = 1'b0;
        m1_req(HASTI_TRANS_NONSEQ, 32'h800, 1'b0, 3'd2);
        smp();
        check("t5_m1_hready_live", m1_hready, 1);
        cyc();
        m1_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        smp();
        check("t5_m1_hready_pend", m1_hready, 0);
        #1;
        hresetn = 1'b0;
        s_hready = 1'b1;
        #1;
        check("t5_rst_htrans", s_htrans, HASTI_TRANS_IDLE);
        check("t5_rst_m0_hready", m0_hready, 1);
        check("t5_rst_m1_hready", m1_hready, 1);
        cyc(); cyc();
        hresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("t5_post_rst_idle", s_htrans, HASTI_TRANS_IDLE);
            cyc();
        end
        m0_req(HASTI_TRANS_NONSEQ, 32'h900, 1'b0, 3'd2);
        push(32'h900, 1'b0, 3'd2);
        smp();
        check("t5_new_req", s_haddr, 32'h900);

        // 6: m1 INCR4 burst is flattened, then an m0 byte write
        cyc();
        m0_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        m1_hburst = 3'd3;
        for (int i = 0; i < 4; i++) begin
            m1_req((i == 0) ? HASTI_TRANS_NONSEQ : HASTI_TRANS_SEQ, 32'h10 + 32'(4 * i), 1'b0, 3'd2);
            push(32'h10 + 32'(4 * i), 1'b0, 3'd2);
            smp();
            check("t6_burst_htrans", s_htrans, HASTI_TRANS_NONSEQ);
            check("t6_burst_haddr", s_haddr, 32'h10 + 32'(4 * i));
            check("t6_burst_hburst", s_hburst, HASTI_BURST_SINGLE);
            cyc();
        end
        m1_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        m1_hburst = HASTI_BURST_SINGLE;
        m0_req(HASTI_TRANS_NONSEQ, 32'h103, 1'b1, 3'd0);
        push(32'h103, 1'b1, 3'd0); wq.push_back(32'h000000AB);
        smp();
        check("t6_byte_haddr", s_haddr, 32'h103);
        check("t6_byte_hsize", s_hsize, 0);
        check("t6_m1_hrdata_last", m1_hrdata, rd_of(32'h1C));
        cyc();
        m0_req(HASTI_TRANS_IDLE, 32'h0, 1'b0, 3'd2);
        m0_hwdata = 32'h000000AB;
        smp();
        check("t6_byte_hwdata", s_hwdata, 32'h000000AB);
        cyc();
        smp();

        check("exp_q_drained", exp_q.size(), 0);
        check("wq_drained", wq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
